// File: rtl/dnn2ami_if.sv
// AMI memory port: one request channel and one in-order response channel.
interface dnn2ami_if #(
  parameter int unsigned AMI_ADDR_WIDTH = 64,
  parameter int unsigned AMI_DATA_WIDTH = 512,
  parameter int unsigned AMI_SIZE_WIDTH = 64
);
  logic                      req_valid;
  logic                      req_is_write;
  logic [AMI_ADDR_WIDTH-1:0] req_addr;
  logic [AMI_DATA_WIDTH-1:0] req_data;
  logic [AMI_SIZE_WIDTH-1:0] req_size;
  logic                      req_grant;

  logic                      resp_valid;
  logic [AMI_DATA_WIDTH-1:0] resp_data;
  logic [AMI_SIZE_WIDTH-1:0] resp_size;
  logic                      resp_grant;

  modport master (
    output req_valid, req_is_write, req_addr, req_data, req_size,
    input  req_grant,
    input  resp_valid, resp_data, resp_size,
    output resp_grant
  );

  modport slave (
    input  req_valid, req_is_write, req_addr, req_data, req_size,
    output req_grant,
    output resp_valid, resp_data, resp_size,
    input  resp_grant
  );
endinterface

// File: rtl/dnn2ami.sv
// DNN buffer/controller to AMI adapter: burst read/write commands become per-word AMI
// requests; writes take priority so reads observe earlier writes.
module dnn2ami #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned NUM_PU         = 2,
  parameter int unsigned PU_ID_WIDTH    = 2,
  parameter int unsigned AMI_ADDR_WIDTH = 64,
  parameter int unsigned AMI_DATA_WIDTH = 512,
  parameter int unsigned AMI_SIZE_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  dnn2ami_if.master                        mem,
  input  logic                             inbuf_full,
  output logic [AXI_DATA_WIDTH-1:0]        data_to_inbuf,
  output logic                             inbuf_push,
  input  logic                             rd_req,
  input  logic [9:0]                       rd_req_size,
  input  logic [AXI_ADDR_WIDTH-1:0]        rd_addr,
  output logic                             rd_ready,
  input  logic [NUM_PU-1:0]                outbuf_empty,
  input  logic [NUM_PU*AXI_DATA_WIDTH-1:0] data_from_outbuf,
  input  logic [NUM_PU-1:0]                write_valid,
  output logic [NUM_PU-1:0]                outbuf_pop,
  input  logic                             wr_req,
  input  logic [PU_ID_WIDTH-1:0]           wr_pu_id,
  input  logic [9:0]                       wr_req_size,
  input  logic [AXI_ADDR_WIDTH-1:0]        wr_addr,
  output logic                             wr_ready,
  output logic                             wr_done
);
  localparam int unsigned WB       = AXI_DATA_WIDTH / 8;
  localparam int unsigned WB_SHIFT = $clog2(WB);

  typedef enum logic {StIdle, StBusy} eng_state_e;

  eng_state_e                wr_state_q, rd_state_q;
  logic [AXI_ADDR_WIDTH-1:0] wr_base_q, rd_base_q;
  logic [9:0]                wr_size_q, wr_cnt_q;
  logic [9:0]                rd_size_q, rd_issue_q, rd_resp_q;
  logic [PU_ID_WIDTH-1:0]    wr_pu_q;

  logic                      wr_pu_ok, wr_left, wr_cand, wr_fire;
  logic                      rd_left, rd_cand, rd_fire, rd_finish, resp_fire;
  logic [NUM_PU-1:0]         pu_sel;
  logic [AXI_DATA_WIDTH-1:0] wr_slice;
  logic [AXI_ADDR_WIDTH-1:0] wr_word_addr, rd_word_addr;
  logic                      unused_resp;

  always_comb begin
    pu_sel   = '0;
    wr_slice = '0;
    for (int p = 0; p < NUM_PU; p++) begin
      if (wr_pu_q == PU_ID_WIDTH'(p)) begin
        pu_sel[p] = 1'b1;
        wr_slice  = data_from_outbuf[p*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  // Out-of-range PU ids are latched as an empty command.
  assign wr_pu_ok = 32'(wr_pu_id) < NUM_PU;

  assign wr_left   = (wr_state_q == StBusy) && (wr_cnt_q != wr_size_q);
  assign wr_cand   = wr_left && |(pu_sel & ~outbuf_empty & write_valid);
  assign wr_fire   = wr_cand && mem.req_grant;
  // Reads wait for all pending writes, not just for write data to be present.
  assign rd_left   = (rd_state_q == StBusy) && (rd_issue_q != rd_size_q);
  assign rd_cand   = rd_left && !wr_left;
  assign rd_fire   = rd_cand && mem.req_grant;
  assign resp_fire = mem.resp_valid && !inbuf_full;
  assign rd_finish = (rd_state_q == StBusy) && (rd_issue_q == rd_size_q) &&
                     (rd_resp_q == rd_size_q);

  assign wr_done = (wr_state_q == StBusy) &&
                   ((wr_size_q == 10'd0) || (wr_fire && (wr_cnt_q + 10'd1 == wr_size_q)));

  assign wr_word_addr = wr_base_q + (AXI_ADDR_WIDTH'(wr_cnt_q) << WB_SHIFT);
  assign rd_word_addr = rd_base_q + (AXI_ADDR_WIDTH'(rd_issue_q) << WB_SHIFT);

  assign mem.req_valid    = wr_cand || rd_cand;
  assign mem.req_is_write = wr_cand;
  assign mem.req_addr     = wr_cand ? AMI_ADDR_WIDTH'(wr_word_addr)
                                    : AMI_ADDR_WIDTH'(rd_word_addr);
  assign mem.req_data     = wr_cand ? AMI_DATA_WIDTH'(wr_slice) : '0;
  assign mem.req_size     = AMI_SIZE_WIDTH'(WB);
  assign mem.resp_grant   = resp_fire;

  assign inbuf_push    = resp_fire;
  assign data_to_inbuf = mem.resp_data[AXI_DATA_WIDTH-1:0];
  assign unused_resp   = ^{mem.resp_data, mem.resp_size};

  assign outbuf_pop = wr_fire ? pu_sel : '0;
  assign wr_ready   = (wr_state_q == StIdle);
  assign rd_ready   = (rd_state_q == StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q <= StIdle;
      wr_base_q  <= '0;
      wr_size_q  <= '0;
      wr_cnt_q   <= '0;
      wr_pu_q    <= '0;
    end else if (wr_state_q == StIdle) begin
      if (wr_req) begin
        wr_state_q <= StBusy;
        wr_base_q  <= wr_addr;
        wr_size_q  <= wr_pu_ok ? wr_req_size : 10'd0;
        wr_cnt_q   <= '0;
        wr_pu_q    <= wr_pu_id;
      end
    end else begin
      if (wr_fire) wr_cnt_q <= wr_cnt_q + 10'd1;
      if (wr_done) wr_state_q <= StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= StIdle;
      rd_base_q  <= '0;
      rd_size_q  <= '0;
      rd_issue_q <= '0;
      rd_resp_q  <= '0;
    end else if (rd_state_q == StIdle) begin
      if (rd_req) begin
        rd_state_q <= StBusy;
        rd_base_q  <= rd_addr;
        rd_size_q  <= rd_req_size;
        rd_issue_q <= '0;
        rd_resp_q  <= '0;
      end
    end else begin
      if (rd_fire)   rd_issue_q <= rd_issue_q + 10'd1;
      if (resp_fire) rd_resp_q  <= rd_resp_q + 10'd1;
      if (rd_finish) rd_state_q <= StIdle;
    end
  end
endmodule

// File: tb/tb_dnn2ami.sv
// Directed bench for dnn2ami: bench-side memory and output-buffer models, hand-computed vectors.
module tb_dnn2ami;
  logic         clk = 1'b0;
  logic         rst;
  logic         inbuf_full;
  logic [63:0]  data_to_inbuf;
  logic         inbuf_push;
  logic         rd_req;
  logic [9:0]   rd_req_size;
  logic [31:0]  rd_addr;
  logic         rd_ready;
  logic [1:0]   outbuf_empty;
  logic [127:0] data_from_outbuf;
  logic [1:0]   write_valid;
  logic [1:0]   outbuf_pop;
  logic         wr_req;
  logic [1:0]   wr_pu_id;
  logic [9:0]   wr_req_size;
  logic [31:0]  wr_addr;
  logic         wr_ready;
  logic         wr_done;

  dnn2ami_if ami ();

  dnn2ami dut (
    .clk              (clk),
    .rst              (rst),
    .mem              (ami),
    .inbuf_full       (inbuf_full),
    .data_to_inbuf    (data_to_inbuf),
    .inbuf_push       (inbuf_push),
    .rd_req           (rd_req),
    .rd_req_size      (rd_req_size),
    .rd_addr          (rd_addr),
    .rd_ready         (rd_ready),
    .outbuf_empty     (outbuf_empty),
    .data_from_outbuf (data_from_outbuf),
    .write_valid      (write_valid),
    .outbuf_pop       (outbuf_pop),
    .wr_req           (wr_req),
    .wr_pu_id         (wr_pu_id),
    .wr_req_size      (wr_req_size),
    .wr_addr          (wr_addr),
    .wr_ready         (wr_ready),
    .wr_done          (wr_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Output-buffer slices count {pu, 16'haaaa, n} and advance on each pop.
  logic [15:0] cnt0 = '0, cnt1 = '0;
  assign data_from_outbuf = {32'd1, 16'haaaa, cnt1, 32'd0, 16'haaaa, cnt0};

  logic [63:0] mem_model [longint];
  logic [63:0] resp_q [$];
  logic [63:0] log_addr [$];
  logic [63:0] log_data [$];
  bit          log_wr [$];
  logic [63:0] push_log [$];
  int          done_cnt = 0, pop0_cnt = 0, pop1_cnt = 0;
  bit          resp_en = 1'b1;

  always @(posedge clk) begin
    if (ami.resp_valid && ami.resp_grant) void'(resp_q.pop_front());
    if (ami.req_valid && ami.req_grant) begin
      log_addr.push_back(ami.req_addr);
      log_data.push_back(ami.req_data[63:0]);
      log_wr.push_back(ami.req_is_write);
      if (ami.req_is_write) mem_model[longint'(ami.req_addr)] = ami.req_data[63:0];
      else resp_q.push_back(mem_model.exists(longint'(ami.req_addr)) ?
                            mem_model[longint'(ami.req_addr)] : 64'hdead_beef_dead_beef);
    end
    if (inbuf_push) push_log.push_back(data_to_inbuf);
    if (wr_done) done_cnt++;
    if (outbuf_pop[0]) begin pop0_cnt++; cnt0 <= cnt0 + 16'd1; end
    if (outbuf_pop[1]) begin pop1_cnt++; cnt1 <= cnt1 + 16'd1; end
  end

  always @(negedge clk) begin
    ami.resp_valid = resp_en && (resp_q.size() > 0);
    ami.resp_data  = {448'd0, (resp_q.size() > 0) ? resp_q[0] : 64'd0};
  end

  initial begin
    bit seen;
    int n_req;
    rst = 1'b0; inbuf_full = 1'b0; rd_req = 1'b0; rd_req_size = '0; rd_addr = '0;
    outbuf_empty = 2'b00; write_valid = 2'b11; wr_req = 1'b0; wr_pu_id = '0;
    wr_req_size = '0; wr_addr = '0; ami.req_grant = 1'b1; ami.resp_size = 64'd8;
    ami.resp_valid = 1'b0; ami.resp_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_ready", 64'(rd_ready), 1);
    check("rst_wr_ready", 64'(wr_ready), 1);
    check("rst_req_valid", 64'(ami.req_valid), 0);
    check("rst_pop", 64'(outbuf_pop), 0);
    check("rst_wr_done", 64'(wr_done), 0);
    rst = 1'b1;

    // Write: pu 1, four words from address 0.
    @(negedge clk);
    wr_req = 1'b1; wr_pu_id = 2'd1; wr_req_size = 10'd4; wr_addr = 32'd0;
    @(negedge clk);
    wr_req = 1'b0; #1;
    check("wr_ready_drop", 64'(wr_ready), 0);
    check("w0_valid", 64'(ami.req_valid), 1);
    check("w0_iswrite", 64'(ami.req_is_write), 1);
    check("w0_addr", ami.req_addr, 64'd0);
    check("w0_data", ami.req_data[63:0], 64'h00000001_aaaa0000);
    check("w0_data_hi", 64'(|ami.req_data[511:64]), 0);
    check("w0_size", ami.req_size, 64'd8);
    check("w0_pop", 64'(outbuf_pop), 64'b10);

    // Stall write data, and post a read while the write is still pending.
    @(negedge clk);
    write_valid = 2'b01; rd_req = 1'b1; rd_addr = 32'd0; rd_req_size = 10'd4; #1;
    check("stall_valid", 64'(ami.req_valid), 0);
    check("stall_pop", 64'(outbuf_pop), 0);
    @(negedge clk);
    rd_req = 1'b0; #1;
    check("rd_ready_drop", 64'(rd_ready), 0);
    check("rd_waits_write", 64'(ami.req_valid), 0);
    rd_req = 1'b1; rd_addr = 32'h100; rd_req_size = 10'd2;
    @(negedge clk);
    rd_req = 1'b0; #1;
    check("stall_valid2", 64'(ami.req_valid), 0);
    write_valid = 2'b11; #1;
    check("w1_addr", ami.req_addr, 64'd8);
    check("w1_data", ami.req_data[63:0], 64'h00000001_aaaa0001);

    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (wr_done) begin seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    check("wr_done_seen", 64'(seen), 1);
    check("w3_addr", ami.req_addr, 64'd24);
    check("w3_data", ami.req_data[63:0], 64'h00000001_aaaa0003);
    inbuf_full = 1'b1;
    @(negedge clk); #1;
    check("wr_ready_back", 64'(wr_ready), 1);
    check("wr_done_pulse", 64'(wr_done), 0);

    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("full_no_grant", 64'(ami.resp_grant), 0);
      check("full_no_push", 64'(inbuf_push), 0);
    end
    check("full_resp_pending", 64'(ami.resp_valid), 1);
    inbuf_full = 1'b0;

    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (rd_ready) begin seen = 1'b1; break; end
    end
    check("rd_ready_back", 64'(seen), 1);
    check("req_count", 64'(log_addr.size()), 8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      check($sformatf("req%0d_iswrite", i), 64'(log_wr[i]), (i < 4) ? 64'd1 : 64'd0);
      check($sformatf("req%0d_addr", i), log_addr[i], 64'((i % 4) * 8));
    end
    for (int i = 0; i < 4 && i < log_data.size(); i++)
      check($sformatf("wdata%0d", i), log_data[i], 64'h00000001_aaaa0000 + 64'(i));
    check("push_count", 64'(push_log.size()), 4);
    for (int i = 0; i < 4 && i < push_log.size(); i++)
      check($sformatf("push%0d", i), push_log[i], 64'h00000001_aaaa0000 + 64'(i));
    check("pop1_count", 64'(pop1_cnt), 4);
    check("pop0_count", 64'(pop0_cnt), 0);
    check("done_count", 64'(done_cnt), 1);

    // Reset in the middle of a read that is never granted.
    ami.req_grant = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h40; rd_req_size = 10'd4;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk); #1;
    check("mid_rd_valid", 64'(ami.req_valid), 1);
    check("mid_rd_addr", ami.req_addr, 64'h40);
    rst = 1'b0; #1;
    check("arst_rd_ready", 64'(rd_ready), 1);
    check("arst_wr_ready", 64'(wr_ready), 1);
    check("arst_req_valid", 64'(ami.req_valid), 0);
    @(negedge clk);
    rst = 1'b1; ami.req_grant = 1'b1;
    n_req = log_addr.size();

    // Size-0 write, then an out-of-range PU id: both complete with no traffic.
    @(negedge clk);
    wr_req = 1'b1; wr_pu_id = 2'd0; wr_req_size = 10'd0; wr_addr = 32'h80;
    @(negedge clk);
    wr_req = 1'b0; #1;
    check("sz0_done", 64'(wr_done), 1);
    check("sz0_no_req", 64'(ami.req_valid), 0);
    @(negedge clk); #1;
    check("sz0_done_pulse", 64'(wr_done), 0);
    check("sz0_ready", 64'(wr_ready), 1);
    wr_req = 1'b1; wr_pu_id = 2'd3; wr_req_size = 10'd4; wr_addr = 32'h0;
    @(negedge clk);
    wr_req = 1'b0; #1;
    check("badpu_done", 64'(wr_done), 1);
    check("badpu_no_req", 64'(ami.req_valid), 0);
    @(negedge clk); #1;
    check("badpu_ready", 64'(wr_ready), 1);
    check("no_new_reqs", 64'(log_addr.size()), 64'(n_req));
    check("done_total", 64'(done_cnt), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
